// File: rtl/sprite_indexador.sv
// Per-pixel sprite engine: finds the highest-priority opaque 16x16 sprite under
// the current pixel and emits its palette index two cycles later.
module sprite_indexador #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               de_in,
  input  logic               bm_we,
  input  logic [2:0]         bm_slot,
  input  logic [7:0]         bm_addr,
  input  logic [7:0]         bm_data,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_slot,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  input  logic               coll_clr,
  output logic [7:0]         indice,
  output logic               de_out,
  output logic [COORD_W-1:0] px_out,
  output logic [COORD_W-1:0] py_out,
  output logic               collision
);

  localparam int XW = COORD_W + 1;

  logic [NUM_SPRITES-1:0]      hit;
  logic [NUM_SPRITES-1:0]      hit1;
  logic [NUM_SPRITES-1:0]      opaque;
  logic [NUM_SPRITES-1:0][7:0] ram_q;
  logic                        de1;
  logic [COORD_W-1:0]          px1;
  logic [COORD_W-1:0]          py1;
  logic [7:0]                  sel_idx;
  logic                        found;
  logic                        multi;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic               sen;
    logic [7:0]         mem [256];
    logic [7:0]         q;
    logic [XW-1:0]      x_end;
    logic [XW-1:0]      y_end;
    logic [3:0]         dx;
    logic [3:0]         dy;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sx  <= '0;
        sy  <= '0;
        sen <= 1'b0;
      end else if (cfg_we && cfg_slot == 3'(g)) begin
        sx  <= cfg_x;
        sy  <= cfg_y;
        sen <= cfg_en;
      end
    end

    // Sprite extent computed one bit wider so sprites at the right/bottom edge clip.
    assign x_end  = {1'b0, sx} + XW'(16);
    assign y_end  = {1'b0, sy} + XW'(16);
    assign hit[g] = de_in & sen & (px >= sx) & ({1'b0, px} < x_end)
                               & (py >= sy) & ({1'b0, py} < y_end);

    // Only the low nibble of the offset addresses the 16x16 bitmap.
    assign dx = px[3:0] - sx[3:0];
    assign dy = py[3:0] - sy[3:0];

    always_ff @(posedge clk) begin
      if (bm_we && bm_slot == 3'(g))
        mem[bm_addr] <= bm_data;
      q <= mem[{dy, dx}];
    end

    assign ram_q[g] = q;
  end

  always_comb begin
    opaque  = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
      opaque[s] = hit1[s] && (ram_q[s] != '0);
      if (opaque[s] && !found) begin
        sel_idx = ram_q[s];
        found   = 1'b1;
      end
    end
    multi = (opaque & (opaque - 1'b1)) != '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit1      <= '0;
      de1       <= 1'b0;
      px1       <= '0;
      py1       <= '0;
      indice    <= '0;
      de_out    <= 1'b0;
      px_out    <= '0;
      py_out    <= '0;
      collision <= 1'b0;
    end else begin
      hit1   <= hit;
      de1    <= de_in;
      px1    <= px;
      py1    <= py;
      indice <= de1 ? sel_idx : '0;
      de_out <= de1;
      px_out <= px1;
      py_out <= py1;
      if (multi)
        collision <= 1'b1;
      else if (coll_clr)
        collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_indexador.sv
// Directed bench for sprite_indexador: expected pixel outputs are queued at
// drive time and compared when they emerge two cycles later.
module tb_sprite_indexador;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] px = '0, py = '0;
  logic          de_in = 1'b0;
  logic          bm_we = 1'b0;
  logic [2:0]    bm_slot = '0;
  logic [7:0]    bm_addr = '0, bm_data = '0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_slot = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0;
  logic          cfg_en = 1'b0;
  logic          coll_clr = 1'b0;
  logic [7:0]    indice;
  logic          de_out;
  logic [CW-1:0] px_out, py_out;
  logic          collision;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          chk;
    logic [7:0]    idx;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } ent_t;

  ent_t q[$];
  ent_t rst_ent = '{chk: 1'b1, idx: 8'h00, de: 1'b0, x: '0, y: '0};

  sprite_indexador #(.NUM_SPRITES(4), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .de_in(de_in),
    .bm_we(bm_we), .bm_slot(bm_slot), .bm_addr(bm_addr), .bm_data(bm_data),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .coll_clr(coll_clr), .indice(indice), .de_out(de_out), .px_out(px_out),
    .py_out(py_out), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive, push expectation, clock, compare the entry now at the output.
  task automatic step(input logic d, input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic c, input logic [7:0] eidx, input logic clr,
                      input logic cchk, input logic ecoll);
    ent_t e;
    de_in = d; px = x; py = y; coll_clr = clr;
    q.push_back('{chk: c, idx: eidx, de: d, x: x, y: y});
    @(posedge clk); #1;
    bm_we = 1'b0; cfg_we = 1'b0; coll_clr = 1'b0; de_in = 1'b0;
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.chk) begin
        chk("indice", 32'(indice), 32'(e.idx));
        chk("de_out", 32'(de_out), 32'(e.de));
        chk("px_out", 32'(px_out), 32'(e.x));
        chk("py_out", 32'(py_out), 32'(e.y));
      end
    end
    if (cchk) chk("collision", 32'(collision), 32'(ecoll));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [7:0] eidx);
    step(1'b1, x, y, 1'b1, eidx, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bmw(input logic [2:0] s, input logic [7:0] a, input logic [7:0] d);
    bm_we = 1'b1; bm_slot = s; bm_addr = a; bm_data = d;
    idle();
  endtask

  task automatic cfgw(input logic [2:0] s, input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic en);
    cfg_we = 1'b1; cfg_slot = s; cfg_x = x; cfg_y = y; cfg_en = en;
    idle();
  endtask

  initial begin
    // Power-on reset, asserted before any clock edge
    #1 rst = 1'b0;
    #2;
    chk("rst_indice", 32'(indice), 32'h0);
    chk("rst_de_out", 32'(de_out), 32'h0);
    chk("rst_px_out", 32'(px_out), 32'h0);
    chk("rst_collision", 32'(collision), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    q.push_back(rst_ent);

    // Basic draw
    cfgw(3'd0, 10'd100, 10'd50, 1'b1);
    bmw(3'd0, 8'h00, 8'h2A);
    bmw(3'd0, 8'hFF, 8'h09);
    pix(10'd100, 10'd50, 8'h2A);
    pix(10'd115, 10'd65, 8'h09);
    pix(10'd116, 10'd65, 8'h00);
    pix(10'd99, 10'd50, 8'h00);
    idle();

    // Transparency and priority
    cfgw(3'd0, 10'd200, 10'd200, 1'b1);
    cfgw(3'd1, 10'd200, 10'd200, 1'b1);
    bmw(3'd0, 8'h00, 8'h00);
    bmw(3'd1, 8'h00, 8'h10);
    pix(10'd200, 10'd200, 8'h10);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    bmw(3'd0, 8'h00, 8'h05);
    pix(10'd200, 10'd200, 8'h05);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

    // Collision clear: set wins while overlap persists, clear works after it ends
    step(1'b1, 10'd200, 10'd200, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
    step(1'b1, 10'd200, 10'd200, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
    step(1'b1, 10'd200, 10'd200, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    // Right-edge clip: texels a wrapped sprite would hit are nonzero
    bmw(3'd2, 8'h03, 8'h33);
    for (int i = 4; i < 8; i++) bmw(3'd2, 8'(i), 8'h77);
    cfgw(3'd2, 10'd1020, 10'd100, 1'b1);
    pix(10'd1023, 10'd100, 8'h33);
    for (int i = 0; i < 4; i++) pix(10'(i), 10'd100, 8'h00);

    // Same-cycle texel rewrite returns old data, new data on next read
    bm_we = 1'b1; bm_slot = 3'd2; bm_addr = 8'h03; bm_data = 8'h55;
    pix(10'd1023, 10'd100, 8'h33);
    pix(10'd1023, 10'd100, 8'h55);

    // Disable takes effect for the pixel sampled after the config edge
    cfg_we = 1'b1; cfg_slot = 3'd2; cfg_x = 10'd1020; cfg_y = 10'd100; cfg_en = 1'b0;
    pix(10'd1023, 10'd100, 8'h55);
    pix(10'd1023, 10'd100, 8'h00);

    // Out-of-range slot writes are ignored
    bmw(3'd7, 8'h03, 8'hEE);
    cfgw(3'd7, 10'd1020, 10'd100, 1'b1);
    pix(10'd1023, 10'd100, 8'h00);
    cfgw(3'd2, 10'd1020, 10'd100, 1'b1);
    pix(10'd1023, 10'd100, 8'h55);
    step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with opaque overlapping sprites active
    pix(10'd200, 10'd200, 8'h05);
    step(1'b1, 10'd200, 10'd200, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
    de_in = 1'b1; px = 10'd200; py = 10'd200;
    #2 rst = 1'b0;
    #1;
    chk("arst_indice", 32'(indice), 32'h0);
    chk("arst_de_out", 32'(de_out), 32'h0);
    chk("arst_collision", 32'(collision), 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    q.push_back(rst_ent);
    idle();
    idle();
    pix(10'd200, 10'd200, 8'h00);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_indexador.md
# sprite_indexador

Per-pixel sprite engine feeding the palette stage: for each pixel coordinate from the VGA timing generator it determines which of NUM_SPRITES 16x16 sprites covers that pixel and emits the 8-bit palette index. Index 0 means transparent, so the downstream palette stage passes the background RGB through. The block also delays the coordinate/enable strobe, so the background generator and palette stage stay aligned with the index. A sticky collision flag reports overlapping opaque sprite pixels.

## Interface
- NUM_SPRITES, 4, number of sprite slots (1-8); slot 0 has highest priority
- COORD_W, 10, width of pixel coordinates
- clk  input  1  pixel clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- px, py  input  COORD_W each  current pixel coordinate
- de_in  input  1  pixel valid (active display)
- bm_we  input  1  bitmap write strobe
- bm_slot  input  3  target slot for bitmap write; values >= NUM_SPRITES ignored
- bm_addr  input  8  texel address {row[3:0], col[3:0]}
- bm_data  input  8  palette index to store
- cfg_we  input  1  slot configuration write strobe
- cfg_slot  input  3  target slot; values >= NUM_SPRITES ignored
- cfg_x, cfg_y  input  COORD_W each  top-left corner of the sprite
- cfg_en  input  1  sprite enable
- coll_clr  input  1  clears collision flag
- indice  output  8  palette index, registered
- de_out  output  1  de_in delayed by 2 cycles
- px_out, py_out  output  COORD_W each  px/py delayed by 2 cycles
- collision  output  1  sticky overlap flag

## Operation
- Per slot: x, y, en registers plus a 256x8 bitmap RAM with synchronous read and one write port.
- On cfg_we, the addressed slot loads cfg_x, cfg_y, cfg_en. On bm_we, the addressed RAM loads bm_data at bm_addr. Both writes may occur in the same cycle.
- Hit test for slot s, evaluated combinationally on the inputs:
  - Condition: de_in & en[s] & px >= x[s] & px < x[s]+16 & py >= y[s] & py < y[s]+16.
  - The sums are computed at COORD_W+1 bits, so a sprite near the maximum coordinate clips and never wraps to 0.
- Stage 1 (edge 1):
  - RAM[s] read address = {py-y[s], px-x[s]}[3:0] pairs.
  - Registered: hit vector, de, px, py.
  - A bitmap write and a read to the same address in the same cycle returns old data.
- Stage 2 (edge 2):
  - opaque[s] = hit1[s] & (ram_q[s] != 0).
  - indice <= ram_q of the lowest-numbered opaque slot; 0 if none, or if de1 = 0.
  - de_out, px_out, py_out <= stage-1 copies.
  - If two or more opaque bits are set, collision <= 1.
- Collision flag:
  - Set only by the condition above.
  - Cleared only by coll_clr.
  - When set and clear coincide, set wins.
- Configuration written at edge k applies to pixels sampled at edge k+1 or later. Changing sprite position mid-frame is legal (tearing is acceptable).

## Timing
- Latency: px/py/de_in sampled at edge N produce indice/de_out/px_out/py_out after edge N+2. Throughput is one pixel per clock with no stalls.
- Reset (rst = 0, asynchronous):
  - Outputs: indice = 0, de_out = 0, px_out = py_out = 0, collision = 0.
  - Slot state: all x = y = 0, en = 0, pipeline registers cleared.
  - Bitmap RAMs are not reset. Their contents are undefined, but because en = 0 the output is indice = 0.
- Reset deasserted mid-frame: the first valid de_out appears 2 edges after the first sampled de_in = 1.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset behaviour: assert rst low mid-stream with de_in = 1 and sprite 0 enabled and opaque. Required: indice, de_out and collision go to 0 immediately without a clock edge. After release, the first de_out = 1 occurs 2 edges after de_in = 1.
- Basic draw:
  - Setup: slot 0 at (100,50), en = 1, texel (row 0, col 0) = 8'h2A, texel (row 15, col 15) = 8'h09.
  - Stimulus: px,py = (100,50) and (115,65).
  - Required: indice 2A and 09, each two cycles later. At (116,65) and (99,50), indice = 0.
- Transparency and priority:
  - Setup: slots 0 and 1 both at (200,200); slot 0 texel = 0, slot 1 texel = 8'h10.
  - Required: indice = 10, collision stays 0.
  - Then set slot 0 texel = 8'h05. Required: indice = 05, collision = 1.
- Collision clear: coll_clr pulse while the overlap persists -> collision remains 1 (set wins). coll_clr after overlap ends -> collision = 0 on the next edge.
- Edge clip: slot 2 at x = 1020 with COORD_W = 10, px = 1023 -> hit; px = 0..3 on the same row -> indice = 0 (no wrap).
- Write/read interactions:
  - Rewrite a texel in the same cycle it is read -> old value output; new value appears on the next read.
  - cfg_we to disable slot at edge k, same coordinate presented at edge k+1 -> indice = 0 at edge k+3.
  - bm_slot/cfg_slot = 7 with NUM_SPRITES = 4 -> no state change.
